fib_gen: RTL and testbench
==========================

Name: fib_gen

Overview:
Streaming Fibonacci sequence generator with a start/ready/valid/done handshake. A start pulse captures a signed count `n`. The block then emits the first `n` Fibonacci numbers (0, 1, 1, 2, …), one per accepted cycle. It sits as a leaf producer feeding a downstream consumer that applies backpressure through `__ready`.

Parameters:
- WIDTH, 32, bit width of `n`, the internal state registers and `__output_0` (signed two's complement).

Ports:
- __clock  in  1  system clock; all state changes on the rising edge.
- __reset  in  1  asynchronous, active-high reset.
- __start  in  1  start pulse; `n` is sampled when it is high.
- __ready  in  1  consumer ready; low stalls the block.
- n  in  WIDTH  signed count of values to produce; needed only while `__start` is high.
- __done  out  1  sequence complete; held until the next start.
- __valid  out  1  `__output_0` holds a new sequence value this cycle.
- __output_0  out  WIDTH  signed sequence value.

Behaviour:
- State registers: a, b, count, n_reg (all WIDTH bits, signed); FSM with states IDLE, RUN, DONE.
- Asynchronous reset (immediate, independent of the clock):
  - FSM goes to IDLE.
  - a=0, b=1, count=0, n_reg=0.
  - `__valid`=0, `__done`=0, `__output_0`=0.
- Start, sampled on the rising edge in any state (start has priority; a start during RUN restarts the sequence):
  - n_reg<=n; a<=0; b<=1; count<=0.
  - `__valid`<=0; `__done`<=0; FSM goes to RUN.
- RUN, with `__ready`=1 on an edge:
  - If count < n_reg (signed compare): `__output_0`<=a, `__valid`<=1, a<=b, b<=a+b, count<=count+1.
  - Otherwise: `__valid`<=0, `__done`<=1, FSM goes to DONE.
- RUN, with `__ready`=0: all registers and outputs hold, including `__valid` and `__output_0`. No value is lost or skipped.
- DONE: `__done`=1 and `__valid`=0 are held until reset or start. `__output_0` holds its last value.
- IDLE: outputs hold their reset values; `__start` is the only thing that leaves IDLE.
- Latency:
  - First value (0) appears registered one clock after the start edge.
  - Values then follow on every edge with `__ready` high.
  - `__done` rises one ready edge after the last value.
  - With n=N and `__ready` held high, `__done` is seen N+1 edges after the start edge.
- n ≤ 0: no valid output; `__done`=1 one edge after start.
- Arithmetic: a+b wraps modulo 2^WIDTH, with no saturation or overflow flag. count is compared signed.
- `n` is ignored except on a start edge; X on `n` at other times must not affect outputs.
- `__valid` and `__done` are never both 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start with n=10 and `__ready`=1 → `__valid`=1 on 10 consecutive edges, `__output_0` = 0,1,1,2,3,5,8,13,21,34; then `__done`=1, `__valid`=0, and `__done` stays 1.
- n=0 → no `__valid` pulse; `__done`=1 on the edge after start. n=-5 → same result.
- n=10 with `__ready` low for 3 cycles after the 4th value (2) → outputs frozen at 2/valid during the stall; sequence resumes with 3,5,…,34; total of exactly 10 values, no duplicates.
- Assert `__reset` asynchronously mid-sequence (after value 5) → `__valid`, `__done` and `__output_0` go to 0 immediately without a clock edge; FSM idles until the next start.
- Finish n=3 (0,1,1; `__done`=1), then start with n=2 → `__done` clears, outputs are 0,1, then `__done` rises again.
- n=50 → values wrap modulo 2^32. The 48th value is F(47)=2971215073, which appears as -1323752223; the bench checks this bit-exactly.

Source files
------------

// File: rtl/fib_gen.sv
// Streaming Fibonacci generator: a start pulse captures a signed count n, then the
// first n Fibonacci numbers are emitted one per ready cycle, followed by a sticky done.
module fib_gen #(
    parameter int WIDTH = 32
) (
    input  logic                    __clock,
    input  logic                    __reset,
    input  logic                    __start,
    input  logic                    __ready,
    input  logic signed [WIDTH-1:0] n,
    output logic                    __done,
    output logic                    __valid,
    output logic signed [WIDTH-1:0] __output_0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic signed [WIDTH-1:0] count_q, count_d;
    logic signed [WIDTH-1:0] n_q, n_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    emit_s;

    // Both operands are signed, so n <= 0 never emits a value.
    assign emit_s = (count_q < n_q);

    // State register.
    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start wins in every state, including a restart mid-run.
    always_comb begin
        state_d = state_q;
        if (__start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (__ready && !emit_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values; a low ready freezes everything.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        count_d = count_q;
        n_d     = n_q;
        out_d   = out_q;
        valid_d = valid_q;
        done_d  = done_q;
        if (__start) begin
            n_d     = n;
            a_d     = '0;
            b_d     = WIDTH'(1);
            count_d = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if ((state_q == RUN) && __ready) begin
            if (emit_s) begin
                out_d   = a_q;
                valid_d = 1'b1;
                a_d     = b_q;
                b_d     = a_q + b_q;
                count_d = count_q + WIDTH'(1);
            end else begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        end else begin
            valid_d = valid_q;
            done_d  = done_q;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            count_q <= '0;
            n_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            count_q <= count_d;
            n_q     <= n_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign __done     = done_q;
    assign __valid    = valid_q;
    assign __output_0 = out_q;

endmodule

// File: tb/tb_fib_gen.sv
// Self-checking bench for fib_gen: table-driven runs plus stall, async reset,
// restart and wrap-around sequences, all checked through a scoreboard queue.
module tb_fib_gen;

    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                ready;
    logic signed [W-1:0] n;
    logic                done;
    logic                valid;
    logic signed [W-1:0] out;

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] sb_q[$];
    logic signed [W-1:0] v47;

    typedef struct {
        int n;
        int cnt;
    } vec_t;

    vec_t vecs[6];
    logic signed [W-1:0] fib10[10];

    always #5 clk = ~clk;

    fib_gen #(.WIDTH(W)) dut (
        .__clock   (clk),
        .__reset   (rst),
        .__start   (start),
        .__ready   (ready),
        .n         (n),
        .__done    (done),
        .__valid   (valid),
        .__output_0(out)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference Fibonacci model with modulo-2^W wrap.
    function automatic void push_model(input int nn);
        logic [W-1:0] fa, fb, t;
        fa = '0;
        fb = 32'd1;
        for (int i = 0; i < nn; i++) begin
            sb_q.push_back(fa);
            t  = fa + fb;
            fa = fb;
            fb = t;
        end
    endfunction

    task automatic start_seq(input int nn, input string tag);
        start = 1'b1;
        n     = nn;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 'x;
        check({tag, "_start_valid"}, valid, 0);
        check({tag, "_start_done"}, done, 0);
    endtask

    task automatic run_seq(input int expn, input string tag, input int stall_after,
                           input int stall_len);
        int edges = 0;
        int got   = 0;
        bit stalled = 1'b0;
        logic signed [W-1:0] last = '0;
        ready = 1'b1;
        for (int cyc = 0; cyc < expn + 5 && done !== 1'b1; cyc++) begin
            @(posedge clk);
            #1;
            edges++;
            check({tag, "_excl"}, valid && done, 0);
            if (valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s_extra: got value %0d want none", tag, out);
                end else begin
                    if (got == 47) v47 = out;
                    check({tag, "_value"}, out, sb_q.pop_front());
                    got++;
                    last = out;
                end
                if (stall_after > 0 && got == stall_after && !stalled) begin
                    stalled = 1'b1;
                    ready   = 1'b0;
                    repeat (stall_len) begin
                        @(posedge clk);
                        #1;
                        check({tag, "_stall_valid"}, valid, 1);
                        check({tag, "_stall_out"}, out, last);
                        check({tag, "_stall_done"}, done, 0);
                    end
                    ready = 1'b1;
                end
            end
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_done_edges"}, edges, expn + 1);
        check({tag, "_count"}, got, expn);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_held"}, done, 1);
        check({tag, "_valid_low"}, valid, 0);
    endtask

    initial begin
        vecs[0] = '{10, 10};
        vecs[1] = '{0, 0};
        vecs[2] = '{-5, 0};
        vecs[3] = '{1, 1};
        vecs[4] = '{3, 3};
        vecs[5] = '{2, 2};
        fib10 = '{32'sd0, 32'sd1, 32'sd1, 32'sd2, 32'sd3, 32'sd5, 32'sd8, 32'sd13,
                  32'sd21, 32'sd34};

        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        n     = '0;
        #2;
        check("reset_valid", valid, 0);
        check("reset_done", done, 0);
        check("reset_out", out, 0);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle_valid", valid, 0);
            check("idle_done", done, 0);
        end

        // Table runs; the n=3 then n=2 pair exercises restart from DONE.
        for (int i = 0; i < 6; i++) begin
            push_model(vecs[i].n);
            start_seq(vecs[i].n, $sformatf("vec%0d", i));
            run_seq(vecs[i].cnt, $sformatf("vec%0d", i), 0, 0);
        end

        // Backpressure after the 4th value, checked against literal expectations.
        for (int i = 0; i < 10; i++) sb_q.push_back(fib10[i]);
        start_seq(10, "stall");
        run_seq(10, "stall", 4, 3);

        // Asynchronous reset mid-sequence, right after value 5.
        push_model(10);
        start_seq(10, "areset");
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("areset_pre_out", out, 5);
        check("areset_pre_valid", valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", valid, 0);
        check("areset_done", done, 0);
        check("areset_out", out, 0);
        #1;
        rst = 1'b0;
        sb_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("areset_idle_valid", valid, 0);
            check("areset_idle_done", done, 0);
        end
        push_model(2);
        start_seq(2, "post_reset");
        run_seq(2, "post_reset", 0, 0);

        // Wrap-around: F(47) does not fit in 32 signed bits.
        v47 = '0;
        push_model(50);
        start_seq(50, "wrap");
        run_seq(50, "wrap", 0, 0);
        check("wrap_f47", v47, -32'sd1323752223);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
